seq_mult_hs: RTL
================

Name: seq_mult_hs

Overview:
- Parametrised iterative shift-add multiplier. It is the sequential successor to the 2x2 combinational LUT multiplier.
- Generalised to WIDTH-bit operands with a signed/unsigned mode and a valid/ready handshake on both input and output.
- Sits between operand producers and result consumers in arithmetic test designs.
- Checked post-route against a behavioural a*b golden model.

Parameters:
- WIDTH, 4, operand width in bits (>=2). The result is 2*WIDTH bits.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b are valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  z holds a completed product
- out_ready  input  1  consumer accepts z this cycle
- z  output  2*WIDTH  product

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - rst asserted at any time, including mid-calculation, clears all state immediately.
  - After reset: state=IDLE, out_valid=0, z=0, internal accumulator/counter=0, in_ready=1.
  - An in-flight operation is discarded and no result is ever produced for it.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready.
- Accept: in_valid & in_ready sampled at a rising edge.
  - Latch the magnitude of a and the magnitude of b. In SIGNED=0 the magnitude is the raw value; in SIGNED=1 it is the absolute value, held in WIDTH-bit unsigned form.
  - Latch neg = SIGNED & (a[MSB]^b[MSB]).
  - Clear the accumulator and set count=0. Next state is CALC.
- CALC: one bit per cycle, LSB first.
  - If mag_b[count]=1, add mag_a<<count into the 2*WIDTH-bit accumulator.
  - Increment count.
  - After the WIDTH-th iteration, go to DONE and load z = neg ? -acc : acc (2*WIDTH-bit two's complement).
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge. With WIDTH=4, accept at edge N gives out_valid=1 after edge N+4.
- DONE:
  - out_valid=1; z is held stable until out_valid & out_ready.
  - On handshake with in_valid=0: next state is IDLE and out_valid=0.
  - On handshake with in_valid=1, i.e. a simultaneous accept: the new operands are latched and the state goes directly to CALC. Throughput is then one result per WIDTH+1 cycles.
  - in_valid with out_ready=0: not accepted. in_ready=0 and the operands are ignored.
- In CALC, in_ready=0. a, b and in_valid are ignored and may change freely.
- z changes only on entry to DONE or on reset. It keeps its last value in IDLE/CALC; consumers qualify it with out_valid.
- Width rules:
  - The accumulator never overflows: the unsigned max is (2^W-1)^2 < 2^(2W).
  - Signed extreme (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) is representable.
  - The most-negative operand magnitude 2^(W-1) fits in WIDTH unsigned bits.
- A zero operand is not shortcut; latency is always WIDTH.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- WIDTH=2, SIGNED=0: drive all 16 a/b combinations with out_ready=1 → z matches a*b each time (e.g. a=3, b=3 → z=4'h9). out_valid occurs 2 edges after each accept.
- WIDTH=8, SIGNED=0: a=8'hFF, b=8'hFF → z=16'hFE01 after 8 edges. Then a=0, b=8'hA5 → z=16'h0000 after 8 edges.
- WIDTH=4, SIGNED=1:
  - a=4'hD (-3), b=4'h5 → z=8'hF1 (-15).
  - a=4'h8, b=4'h8 → z=8'h40 (64).
  - a=4'h8, b=4'h7 → z=8'hC8 (-56).
- Backpressure, WIDTH=4: hold out_ready=0 for 6 cycles after out_valid with in_valid=1 and changing a/b. Required: z is stable, in_ready=0, and nothing is accepted. Then out_ready=1 together with in_valid=1 → the handshake and a new accept happen in the same cycle, and the next out_valid comes 4 edges later.
- Reset mid-CALC: assert rst asynchronously 2 cycles after an accept (between clock edges) → out_valid=0, z=0 and in_ready=1 immediately. After release, no stale result appears and the next operation (a=6, b=7, unsigned) gives z=8'h2A.
- Random soak: 1000 random a/b pairs with random in_valid/out_ready, SIGNED=0 and SIGNED=1, WIDTH=4 and 8. The scoreboard compares every product in order against a*b; zero mismatches are required.

Source files
------------

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative shift-add multiplier, one operand bit per cycle, valid/ready on both sides
module seq_mult_hs #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t               state_q;
  logic [2*WIDTH-1:0]   mag_a_q, acc_q, z_q, acc_d;
  logic [WIDTH-1:0]     mag_b_q, mag_a_d, mag_b_d;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q, out_valid_q, accept;
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign mag_a_d   = (SIGNED && a[WIDTH-1]) ? -a : a;
  assign mag_b_d   = (SIGNED && b[WIDTH-1]) ? -b : b;
  // multiplicand shifts left and multiplier right, so bit 0 always selects the current partial product
  assign acc_d     = acc_q + (mag_b_q[0] ? mag_a_q : '0);
  assign out_valid = out_valid_q;
  assign z         = z_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      mag_a_q     <= {{WIDTH{1'b0}}, mag_a_d};
      mag_b_q     <= mag_b_d;
      neg_q       <= SIGNED & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= CALC;
    end else if (state_q == CALC) begin
      acc_q   <= acc_d;
      mag_a_q <= mag_a_q << 1;
      mag_b_q <= mag_b_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH-1)) begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        z_q         <= neg_q ? -acc_d : acc_d;
      end
    end else if (state_q == DONE && out_ready) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end
  end
endmodule
